arf_sched: RTL

ARF_SCHED -- requirements
Module: arf_sched

---
 rtl/arf_sched.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/arf_sched.sv
// arf_sched: evaluates the ARF dataflow graph over 26 loaded operands using a
// single shared W x W multiplier and a single shared W-bit adder, driven by a
// fixed 20-step micro-schedule, then returns the two results as a 2-beat burst.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the producer holds data stable while valid && !ready, and the ready/
// valid outputs of this block depend only on state, never on the peer's input.
module arf_sched #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        COMP = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Register file layout: operands 0..25 in load order, temporaries above.
    localparam int RF_N = 54;

    localparam logic [5:0] NA  = 6'd0;
    localparam logic [5:0] A1  = 6'd0;
    localparam logic [5:0] B1  = 6'd1;
    localparam logic [5:0] A2  = 6'd2;
    localparam logic [5:0] B2  = 6'd3;
    localparam logic [5:0] A3  = 6'd4;
    localparam logic [5:0] B3  = 6'd5;
    localparam logic [5:0] A4  = 6'd6;
    localparam logic [5:0] B4  = 6'd7;
    localparam logic [5:0] A5  = 6'd8;
    localparam logic [5:0] B5  = 6'd9;
    localparam logic [5:0] A6  = 6'd10;
    localparam logic [5:0] B6  = 6'd11;
    localparam logic [5:0] A7  = 6'd12;
    localparam logic [5:0] B7  = 6'd13;
    localparam logic [5:0] A8  = 6'd14;
    localparam logic [5:0] B8  = 6'd15;
    localparam logic [5:0] C13 = 6'd16;
    localparam logic [5:0] C14 = 6'd17;
    localparam logic [5:0] C15 = 6'd18;
    localparam logic [5:0] C16 = 6'd19;
    localparam logic [5:0] C17 = 6'd20;
    localparam logic [5:0] C18 = 6'd21;
    localparam logic [5:0] C21 = 6'd22;
    localparam logic [5:0] C22 = 6'd23;
    localparam logic [5:0] C23 = 6'd24;
    localparam logic [5:0] C24 = 6'd25;
    localparam logic [5:0] P1  = 6'd26;
    localparam logic [5:0] P2  = 6'd27;
    localparam logic [5:0] P3  = 6'd28;
    localparam logic [5:0] P4  = 6'd29;
    localparam logic [5:0] P5  = 6'd30;
    localparam logic [5:0] P6  = 6'd31;
    localparam logic [5:0] P7  = 6'd32;
    localparam logic [5:0] P8  = 6'd33;
    localparam logic [5:0] S9  = 6'd34;
    localparam logic [5:0] S10 = 6'd35;
    localparam logic [5:0] S11 = 6'd36;
    localparam logic [5:0] S12 = 6'd37;
    localparam logic [5:0] S13 = 6'd38;
    localparam logic [5:0] S14 = 6'd39;
    localparam logic [5:0] M15 = 6'd40;
    localparam logic [5:0] M16 = 6'd41;
    localparam logic [5:0] M17 = 6'd42;
    localparam logic [5:0] M18 = 6'd43;
    localparam logic [5:0] S19 = 6'd44;
    localparam logic [5:0] S20 = 6'd45;
    localparam logic [5:0] M21 = 6'd46;
    localparam logic [5:0] M22 = 6'd47;
    localparam logic [5:0] M23 = 6'd48;
    localparam logic [5:0] M24 = 6'd49;
    localparam logic [5:0] S25 = 6'd50;
    localparam logic [5:0] S26 = 6'd51;
    localparam logic [5:0] Y0  = 6'd52;
    localparam logic [5:0] Y1  = 6'd53;

    localparam logic [4:0] LAST_WORD = 5'd25;
    localparam logic [4:0] COMP_LAST = 5'd19;

    // One micro-op per COMP cycle: an optional multiply and an optional add.
    typedef struct packed {
        logic       mul_en;
        logic [5:0] ma;
        logic [5:0] mb;
        logic [5:0] md;
        logic       add_en;
        logic [5:0] aa;
        logic [5:0] ab;
        logic [5:0] ad;
    } uop_t;

    function automatic uop_t mk(input logic me, input logic [5:0] ma, input logic [5:0] mb,
                                input logic [5:0] md, input logic ae, input logic [5:0] aa,
                                input logic [5:0] ab, input logic [5:0] ad);
        uop_t u;
        u.mul_en = me;
        u.ma     = ma;
        u.mb     = mb;
        u.md     = md;
        u.add_en = ae;
        u.aa     = aa;
        u.ab     = ab;
        u.ad     = ad;
        return u;
    endfunction

    state_t       state;
    state_t       state_next;
    logic [4:0]   cnt;
    logic [4:0]   cnt_next;
    logic         load_en;
    logic         comp_en;
    uop_t         uop;
    logic [W-1:0] rf [RF_N];
    logic [W-1:0] mul_res;
    logic [W-1:0] add_res;

    // State and counter register; cnt is the load index, COMP step or OUT beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic and handshake outputs, all derived from state only.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b0;
        load_en    = 1'b0;
        comp_en    = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_en = 1'b1;
                    if (cnt == LAST_WORD) begin
                        state_next = COMP;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 5'd1;
                    end
                end
            end
            COMP: begin
                busy    = 1'b1;
                comp_en = 1'b1;
                if (cnt == COMP_LAST) begin
                    state_next = OUT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 5'd1;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = cnt[0];
                if (out_ready) begin
                    if (cnt[0]) begin
                        state_next = LOAD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = 5'd1;
                    end
                end
            end
            default: begin
                state_next = LOAD;
                cnt_next   = '0;
            end
        endcase
    end

    // Micro-schedule: each step only reads values written on an earlier step.
    always_comb begin
        uop = '0;
        case (cnt)
            5'd0:  uop = mk(1'b1, A1,  B1,  P1,  1'b0, NA,  NA,  NA);
            5'd1:  uop = mk(1'b1, A2,  B2,  P2,  1'b0, NA,  NA,  NA);
            5'd2:  uop = mk(1'b1, A3,  B3,  P3,  1'b1, P1,  P2,  S9);
            5'd3:  uop = mk(1'b1, A4,  B4,  P4,  1'b0, NA,  NA,  NA);
            5'd4:  uop = mk(1'b1, A5,  B5,  P5,  1'b1, P3,  P4,  S10);
            5'd5:  uop = mk(1'b1, A6,  B6,  P6,  1'b1, S10, C13, S13);
            5'd6:  uop = mk(1'b1, A7,  B7,  P7,  1'b1, P5,  P6,  S11);
            5'd7:  uop = mk(1'b1, A8,  B8,  P8,  1'b1, S11, C14, S14);
            5'd8:  uop = mk(1'b1, S13, C15, M15, 1'b1, P7,  P8,  S12);
            5'd9:  uop = mk(1'b1, S13, C17, M17, 1'b0, NA,  NA,  NA);
            5'd10: uop = mk(1'b1, S14, C16, M16, 1'b0, NA,  NA,  NA);
            5'd11: uop = mk(1'b1, S14, C18, M18, 1'b1, M15, M16, S19);
            5'd12: uop = mk(1'b1, S19, C21, M21, 1'b1, M17, M18, S20);
            5'd13: uop = mk(1'b1, S19, C23, M23, 1'b0, NA,  NA,  NA);
            5'd14: uop = mk(1'b1, S20, C22, M22, 1'b0, NA,  NA,  NA);
            5'd15: uop = mk(1'b1, S20, C24, M24, 1'b0, NA,  NA,  NA);
            5'd16: uop = mk(1'b0, NA,  NA,  NA,  1'b1, M21, M22, S25);
            5'd17: uop = mk(1'b0, NA,  NA,  NA,  1'b1, M23, M24, S26);
            5'd18: uop = mk(1'b0, NA,  NA,  NA,  1'b1, S9,  S25, Y0);
            5'd19: uop = mk(1'b0, NA,  NA,  NA,  1'b1, S12, S26, Y1);
            default: uop = '0;
        endcase
    end

    // The one shared multiplier and the one shared adder, truncated to W bits.
    always_comb begin
        mul_res = rf[uop.ma] * rf[uop.mb];
        add_res = rf[uop.aa] + rf[uop.ab];
    end

    // Register file: operand capture in LOAD, result write-back in COMP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RF_N; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (load_en) begin
                rf[{1'b0, cnt}] <= in_data;
            end
            if (comp_en && uop.mul_en) begin
                rf[uop.md] <= mul_res;
            end
            if (comp_en && uop.add_en) begin
                rf[uop.ad] <= add_res;
            end
        end
    end

    // Result word is zero outside OUT so nothing stale is ever presented.
    always_comb begin
        out_data = '0;
        if (state == OUT) begin
            out_data = cnt[0] ? rf[Y1] : rf[Y0];
        end
    end

endmodule
